serial_mag_comparator: RTL and testbench
========================================

# serial_mag_comparator

Parametrised, bit-serial magnitude comparator: successor to the combinational byte equality comparator. Latches two WIDTH-bit operands on a start request and scans them MSB-first, one bit per enabled clock. It terminates early at the first differing bit and reports equal, less-than and greater-than results with a done pulse. Supports unsigned and two's-complement modes and keeps a saturating count of equal results. Sits between operand-producing datapath logic and downstream control that needs ordered comparison at low gate cost.

## Interface
- WIDTH, 8, operand width in bits; WIDTH >= 2.
- CNT_W, 8, width of the equal-result counter; CNT_W >= 1.

- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  global enable; when low, every register holds its value.
- start  input  1  request a comparison; accepted only in IDLE with en=1.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- signed_mode  input  1  1 = two's-complement compare; sampled on the accepting edge.
- busy  output  1  high while in CMP.
- done  output  1  one-enabled-cycle pulse on completion.
- eq  output  1  A == B for the last completed compare.
- lt  output  1  A < B for the last completed compare.
- gt  output  1  A > B for the last completed compare.
- match_cnt  output  CNT_W  count of completed compares with eq=1; saturates at 2^CNT_W-1.

## Operation
- States: IDLE and CMP. Internal registers:
  - a_q, b_q (WIDTH).
  - sgn_q.
  - idx: ceil(log2(WIDTH)) bits, bit index.
- IDLE, en=1, start=1:
  - Latch a, b and signed_mode.
  - Set idx = WIDTH-1 and clear eq/lt/gt to 0.
  - Go to CMP.
  - After acceptance, a/b/signed_mode may change freely.
- CMP, en=1, examine bit idx of a_q and b_q:
  - Bits differ, unsigned, or signed with idx < WIDTH-1: gt = a_q[idx], lt = b_q[idx]. Set done, go to IDLE.
  - Bits differ, signed, idx = WIDTH-1 (sign bit): gt = b_q[idx], lt = a_q[idx]. Set done, go to IDLE.
  - Bits equal, idx = 0: eq = 1, done set, match_cnt increments unless already all-ones, go to IDLE.
  - Bits equal, idx > 0: idx decrements.
- Exactly one of eq/lt/gt is 1 after any completion. All three are 0 after reset and from acceptance until completion.
- eq/lt/gt hold until the next accepted start or reset.
- match_cnt never wraps and is cleared only by reset.
- start while busy is ignored; no queuing.

## Timing
- Reset (asynchronous, any time, including mid-compare): state = IDLE, busy = 0, done = 0, eq = lt = gt = 0, match_cnt = 0, idx = 0, operand registers = 0.
- Edge E0 accepts start. busy is high from after E0 until the completing edge.
- Edge Ej (j >= 1, enabled edges only) examines bit WIDTH-j.
- First difference at bit k: completion at enabled edge E(WIDTH-k), so latency is WIDTH-k cycles.
- Equal operands: completion at E(WIDTH), the worst-case latency.
- done is registered:
  - high for the cycle after the completing edge; busy is low in that cycle.
  - falls at the next enabled edge.
  - while en=0, done stays high until an enabled edge.
- Back-to-back operation: start asserted during the done cycle is accepted at that edge. done falls and busy rises on the same edge, giving no dead cycle.
- en low for n cycles during CMP adds exactly n cycles of latency. Results are unchanged.

## Test plan
- Unsigned equal: WIDTH=8, a=b=8'h5A, signed_mode=0, start at E0.
  - Required response: busy for 8 cycles, then done after E8 with eq=1, lt=gt=0, match_cnt=1.
- MSB difference in both modes: a=8'h80, b=8'h7F.
  - signed_mode=0: done after E1 with gt=1.
  - Repeat with signed_mode=1: done after E1 with lt=1.
  - match_cnt unchanged.
- LSB difference: a=8'h03, b=8'h02, unsigned.
  - Required response: done after E8 with gt=1.
  - Then a=8'hFE, b=8'hFF, signed: done after E8 with lt=1.
- Enable stall and ignored start: a=8'h10, b=8'h10.
  - Drop en for 3 cycles after E2: done appears 3 cycles later than the stall-free run, with eq=1.
  - A start pulse with new operands while busy is ignored: results still reflect 8'h10 vs 8'h10.
- Back-to-back compares and reset mid-operation:
  - Assert start in the done cycle: the second compare is accepted with no gap.
  - Assert rst at E4 of that second compare: all outputs 0 immediately, including match_cnt.
  - After release, start is accepted normally.
- Counter saturation: CNT_W=2, five equal compares.
  - Required response: match_cnt goes 1, 2, 3, 3, 3; eq=1 each time.

Source files
------------

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator with early exit on the first differing bit,
// unsigned/two's-complement modes and a saturating count of equal results.
module serial_mag_comparator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sgn_r;
    logic [IDX_W-1:0] idx_r;

    logic bit_a_s;
    logic bit_b_s;
    logic differ_s;
    logic invert_s;

    // Current bit pair under examination and whether sign-bit ordering applies
    always_comb begin
        bit_a_s  = a_r[idx_r];
        bit_b_s  = b_r[idx_r];
        differ_s = bit_a_s ^ bit_b_s;
        invert_s = sgn_r & (idx_r == IDX_W'(WIDTH - 1));
    end

    // Control FSM, operand shadow registers and registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            sgn_r     <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
            match_cnt <= {CNT_W{1'b0}};
        end else if (en) begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        sgn_r   <= signed_mode;
                        idx_r   <= IDX_W'(WIDTH - 1);
                        eq      <= 1'b0;
                        lt      <= 1'b0;
                        gt      <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= CMP;
                    end
                end
                CMP: begin
                    if (differ_s) begin
                        // A set sign bit means the negative operand, so ordering flips there
                        gt      <= invert_s ? bit_b_s : bit_a_s;
                        lt      <= invert_s ? bit_a_s : bit_b_s;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else if (idx_r == {IDX_W{1'b0}}) begin
                        eq      <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                        if (match_cnt != {CNT_W{1'b1}}) begin
                            match_cnt <= match_cnt + CNT_W'(1);
                        end
                    end else begin
                        idx_r <= idx_r - IDX_W'(1);
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed self-checking bench for serial_mag_comparator; a second instance with a
// 2-bit counter exercises saturation.
module tb_serial_mag_comparator;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       start;
    logic       start2;
    logic [7:0] a;
    logic [7:0] b;
    logic       signed_mode;
    logic       busy, done, eq, lt, gt;
    logic [7:0] match_cnt;
    logic       busy2, done2, eq2, lt2, gt2;
    logic [1:0] match_cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_mag_comparator #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .a(a), .b(b),
        .signed_mode(signed_mode), .busy(busy), .done(done), .eq(eq), .lt(lt),
        .gt(gt), .match_cnt(match_cnt)
    );

    serial_mag_comparator #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .start(start2), .a(a), .b(b),
        .signed_mode(signed_mode), .busy(busy2), .done(done2), .eq(eq2), .lt(lt2),
        .gt(gt2), .match_cnt(match_cnt2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Launch a compare on dut and return the number of edges after acceptance until done is seen
    task automatic run_cmp(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                           output int lat);
        a = av;
        b = bv;
        signed_mode = sv;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy, done, eq, lt, gt} !== 5'b00000)
            $display("FAIL reset_flags: got %b expected 00000", {busy, done, eq, lt, gt});
        else n_pass++;
        n_checks++;
        if (match_cnt !== 8'd0 || match_cnt2 !== 2'd0)
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", match_cnt, match_cnt2);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned_equal;
        int lat;
        a = 8'h5A;
        b = 8'h5A;
        signed_mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL eq_busy_after_accept: got busy=%b done=%b expected 1 0", busy, done);
        else n_pass++;
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== 8) $display("FAIL eq_latency: got %0d expected 8", lat);
        else n_pass++;
        n_checks++;
        if ({busy, eq, lt, gt} !== 4'b0100)
            $display("FAIL eq_result: got busy/eq/lt/gt=%b expected 0100", {busy, eq, lt, gt});
        else n_pass++;
        n_checks++;
        if (match_cnt !== 8'd1) $display("FAIL eq_count: got %0d expected 1", match_cnt);
        else n_pass++;
        tick();
        n_checks++;
        if (done !== 1'b0) $display("FAIL done_pulse_width: got %b expected 0", done);
        else n_pass++;
    endtask

    task automatic test_msb_diff;
        int lat;
        run_cmp(8'h80, 8'h7F, 1'b0, lat);
        n_checks++;
        if (lat !== 1 || {eq, lt, gt} !== 3'b001)
            $display("FAIL msb_unsigned: got lat=%0d eq/lt/gt=%b expected 1 001", lat, {eq, lt, gt});
        else n_pass++;
        tick();
        run_cmp(8'h80, 8'h7F, 1'b1, lat);
        n_checks++;
        if (lat !== 1 || {eq, lt, gt} !== 3'b010)
            $display("FAIL msb_signed: got lat=%0d eq/lt/gt=%b expected 1 010", lat, {eq, lt, gt});
        else n_pass++;
        n_checks++;
        if (match_cnt !== 8'd1) $display("FAIL msb_count: got %0d expected 1", match_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_lsb_diff;
        int lat;
        run_cmp(8'h03, 8'h02, 1'b0, lat);
        n_checks++;
        if (lat !== 8 || {eq, lt, gt} !== 3'b001)
            $display("FAIL lsb_unsigned: got lat=%0d eq/lt/gt=%b expected 8 001", lat, {eq, lt, gt});
        else n_pass++;
        tick();
        run_cmp(8'hFE, 8'hFF, 1'b1, lat);
        n_checks++;
        if (lat !== 8 || {eq, lt, gt} !== 3'b010)
            $display("FAIL lsb_signed: got lat=%0d eq/lt/gt=%b expected 8 010", lat, {eq, lt, gt});
        else n_pass++;
        tick();
    endtask

    task automatic test_stall_ignored_start;
        int lat;
        a = 8'h10;
        b = 8'h10;
        signed_mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        lat = 2;
        en = 1'b0;
        repeat (3) begin
            tick();
            lat++;
        end
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL stall_hold: got busy=%b done=%b expected 1 0", busy, done);
        else n_pass++;
        en = 1'b1;
        a = 8'h01;
        b = 8'h02;
        signed_mode = 1'b1;
        start = 1'b1;
        tick();
        lat++;
        start = 1'b0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== 11) $display("FAIL stall_latency: got %0d expected 11", lat);
        else n_pass++;
        n_checks++;
        if ({eq, lt, gt} !== 3'b100)
            $display("FAIL ignored_start_result: got eq/lt/gt=%b expected 100", {eq, lt, gt});
        else n_pass++;
        n_checks++;
        if (match_cnt !== 8'd2) $display("FAIL stall_count: got %0d expected 2", match_cnt);
        else n_pass++;
        en = 1'b0;
        tick();
        tick();
        n_checks++;
        if (done !== 1'b1) $display("FAIL done_hold_en_low: got %b expected 1", done);
        else n_pass++;
        en = 1'b1;
        tick();
        n_checks++;
        if (done !== 1'b0 || {eq, lt, gt} !== 3'b100)
            $display("FAIL done_fall_results_hold: got done=%b eq/lt/gt=%b expected 0 100",
                     done, {eq, lt, gt});
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int lat;
        run_cmp(8'h80, 8'h7F, 1'b0, lat);
        a = 8'h33;
        b = 8'h33;
        signed_mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || {eq, lt, gt} !== 3'b000)
            $display("FAIL b2b_accept: got busy=%b done=%b eq/lt/gt=%b expected 1 0 000",
                     busy, done, {eq, lt, gt});
        else n_pass++;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, eq, lt, gt} !== 5'b00000 || match_cnt !== 8'd0)
            $display("FAIL mid_reset: got flags=%b cnt=%0d expected 00000 0",
                     {busy, done, eq, lt, gt}, match_cnt);
        else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        run_cmp(8'h22, 8'h22, 1'b0, lat);
        n_checks++;
        if (lat !== 8 || eq !== 1'b1 || match_cnt !== 8'd1)
            $display("FAIL post_reset_cmp: got lat=%0d eq=%b cnt=%0d expected 8 1 1",
                     lat, eq, match_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_saturation;
        int lat;
        logic [1:0] exp_cnt;
        for (int i = 0; i < 5; i++) begin
            exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
            a = 8'hC3;
            b = 8'hC3;
            signed_mode = 1'b0;
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            lat = 0;
            while (!done2 && lat < 40) begin
                tick();
                lat++;
            end
            n_checks++;
            if (done2 !== 1'b1 || eq2 !== 1'b1 || match_cnt2 !== exp_cnt)
                $display("FAIL sat_%0d: got done=%b eq=%b cnt=%0d expected 1 1 %0d",
                         i, done2, eq2, match_cnt2, exp_cnt);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        a = 8'h00;
        b = 8'h00;
        signed_mode = 1'b0;
        test_reset();
        test_unsigned_equal();
        test_msb_diff();
        test_lsb_diff();
        test_stall_ignored_start();
        test_back_to_back();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
